int_issue_queue: RTL and testbench

INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

---
 rtl/int_issue_queue.sv | 133 +++++++++++++
 tb/tb_int_issue_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_issue_queue.sv
// Age-ordered shifting issue queue for integer ALU instructions.
// Index 0 is the oldest entry; CDB broadcasts wake pending operands.
module int_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            dispatch_en,
    input  logic [3:0]      dispatch_opcode,
    input  logic [31:0]     dispatch_rsdata,
    input  logic [31:0]     dispatch_rtdata,
    input  logic            dispatch_rsvalid,
    input  logic            dispatch_rtvalid,
    input  logic [TAGW-1:0] dispatch_rstag,
    input  logic [TAGW-1:0] dispatch_rttag,
    input  logic [TAGW-1:0] dispatch_rdtag,
    output logic            queue_full,
    input  logic            cdb_valid,
    input  logic [TAGW-1:0] cdb_tag,
    input  logic [31:0]     cdb_data,
    output logic            ready_int,
    output logic [3:0]      opcode,
    output logic [31:0]     rsdata,
    output logic [31:0]     rtdata,
    output logic [TAGW-1:0] rdtag,
    input  logic            issue_int
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic            valid;
        logic [3:0]      op;
        logic            rsv;
        logic [TAGW-1:0] rst;
        logic [31:0]     rsd;
        logic            rtv;
        logic [TAGW-1:0] rtt;
        logic [31:0]     rtd;
        logic [TAGW-1:0] rd;
    } entry_t;

    entry_t          r_q [DEPTH];
    logic [CW-1:0]   r_count;

    logic [DEPTH-1:0] w_ready;
    logic             w_any;
    logic [SW-1:0]    w_sel;
    logic             w_issue;
    logic             w_disp;
    logic [CW-1:0]    w_widx;
    entry_t           w_new;
    entry_t           w_woke [DEPTH+1];
    entry_t           w_nxt  [DEPTH];

    // Selection looks only at registered state, so a wakeup is visible one cycle later.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_ready = '0;
        w_sel   = '0;
        for (int i = 0; i < DEPTH; i++)
            w_ready[i] = r_q[i].valid & r_q[i].rsv & r_q[i].rtv;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (w_ready[i]) w_sel = SW'(i);
        w_any = |w_ready;
    end

    assign ready_int  = w_any;
    assign opcode     = w_any ? r_q[w_sel].op  : '0;
    assign rsdata     = w_any ? r_q[w_sel].rsd : '0;
    assign rtdata     = w_any ? r_q[w_sel].rtd : '0;
    assign rdtag      = w_any ? r_q[w_sel].rd  : '0;
    assign queue_full = (r_count == CW'(DEPTH));

    assign w_issue = issue_int & w_any;
    assign w_disp  = dispatch_en & ~queue_full & ~flush;
    assign w_widx  = r_count - CW'(w_issue);

    always_comb begin
        w_new       = '0;
        w_new.valid = 1'b1;
        w_new.op    = dispatch_opcode;
        w_new.rst   = dispatch_rstag;
        w_new.rtt   = dispatch_rttag;
        w_new.rd    = dispatch_rdtag;
        w_new.rsv   = dispatch_rsvalid | (cdb_valid && dispatch_rstag == cdb_tag);
        w_new.rsd   = dispatch_rsvalid ? dispatch_rsdata : cdb_data;
        w_new.rtv   = dispatch_rtvalid | (cdb_valid && dispatch_rttag == cdb_tag);
        w_new.rtd   = dispatch_rtvalid ? dispatch_rtdata : cdb_data;

        for (int i = 0; i < DEPTH; i++) begin
            w_woke[i] = r_q[i];
            if (cdb_valid && !r_q[i].rsv && r_q[i].rst == cdb_tag) begin
                w_woke[i].rsv = 1'b1;
                w_woke[i].rsd = cdb_data;
            end
            if (cdb_valid && !r_q[i].rtv && r_q[i].rtt == cdb_tag) begin
                w_woke[i].rtv = 1'b1;
                w_woke[i].rtd = cdb_data;
            end
        end
        w_woke[DEPTH] = '0;

        // Entries at or above the issued slot move down one; the new entry lands at the tail.
        for (int i = 0; i < DEPTH; i++) begin
            w_nxt[i] = (w_issue && i >= int'(w_sel)) ? w_woke[i+1] : w_woke[i];
            if (w_disp && w_widx == CW'(i))
                w_nxt[i] = w_new;
            if (flush)
                w_nxt[i].valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: only valid bits are reset; payload fields are don't-care while invalid.
            for (int i = 0; i < DEPTH; i++)
                r_q[i].valid <= 1'b0;
            r_count <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            r_q <= w_nxt;
            if (flush)
                r_count <= '0;
            else
                r_count <= r_count + CW'(w_disp) - CW'(w_issue);
        end
    end

endmodule

// File: tb/tb_int_issue_queue.sv
// Self-checking bench for int_issue_queue: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.
module tb_int_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAGW  = 6;

    logic            clk = 1'b0;
    logic            reset, flush, dispatch_en;
    logic [3:0]      dispatch_opcode;
    logic [31:0]     dispatch_rsdata, dispatch_rtdata;
    logic            dispatch_rsvalid, dispatch_rtvalid;
    logic [TAGW-1:0] dispatch_rstag, dispatch_rttag, dispatch_rdtag;
    logic            queue_full;
    logic            cdb_valid;
    logic [TAGW-1:0] cdb_tag;
    logic [31:0]     cdb_data;
    logic            ready_int;
    logic [3:0]      opcode;
    logic [31:0]     rsdata, rtdata;
    logic [TAGW-1:0] rdtag;
    logic            issue_int;

    int n_checks = 0;
    int n_fail   = 0;

    int_issue_queue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_en(dispatch_en), .dispatch_opcode(dispatch_opcode),
        .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
        .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
        .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
        .dispatch_rdtag(dispatch_rdtag), .queue_full(queue_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ready_int(ready_int), .opcode(opcode), .rsdata(rsdata), .rtdata(rtdata),
        .rdtag(rdtag), .issue_int(issue_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      op;
        bit              rsv;
        logic [TAGW-1:0] rst;
        logic [31:0]     rsd;
        bit              rtv;
        logic [TAGW-1:0] rtt;
        logic [31:0]     rtd;
        logic [TAGW-1:0] rd;
    } ment_t;

    ment_t mq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_ready();
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].rsv && mq[i].rtv) return i;
        return -1;
    endfunction

    // Apply one clock of the architectural rules to the model using the current inputs.
    task automatic model_update();
        int  k;
        bit  was_full;
        ment_t e;
        if (reset || flush) begin
            mq.delete();
            return;
        end
        k = first_ready();
        was_full = (mq.size() == DEPTH);
        if (issue_int && k >= 0) mq.delete(k);
        if (cdb_valid) begin
            for (int i = 0; i < mq.size(); i++) begin
                e = mq[i];
                if (!e.rsv && e.rst == cdb_tag) begin e.rsv = 1; e.rsd = cdb_data; end
                if (!e.rtv && e.rtt == cdb_tag) begin e.rtv = 1; e.rtd = cdb_data; end
                mq[i] = e;
            end
        end
        if (dispatch_en && !was_full) begin
            e.op  = dispatch_opcode;
            e.rd  = dispatch_rdtag;
            e.rst = dispatch_rstag;
            e.rtt = dispatch_rttag;
            e.rsv = dispatch_rsvalid;
            e.rsd = dispatch_rsdata;
            e.rtv = dispatch_rtvalid;
            e.rtd = dispatch_rtdata;
            if (cdb_valid && !e.rsv && e.rst == cdb_tag) begin e.rsv = 1; e.rsd = cdb_data; end
            if (cdb_valid && !e.rtv && e.rtt == cdb_tag) begin e.rtv = 1; e.rtd = cdb_data; end
            mq.push_back(e);
        end
    endtask

    task automatic compare(input string where);
        int k;
        k = first_ready();
        chk({where, ".ready_int"},  ready_int,  k >= 0);
        chk({where, ".queue_full"}, queue_full, mq.size() == DEPTH);
        chk({where, ".count"},      dut.r_count, mq.size());
        chk({where, ".opcode"},     opcode, (k >= 0) ? mq[k].op  : 4'h0);
        chk({where, ".rsdata"},     rsdata, (k >= 0) ? mq[k].rsd : 32'h0);
        chk({where, ".rtdata"},     rtdata, (k >= 0) ? mq[k].rtd : 32'h0);
        chk({where, ".rdtag"},      rdtag,  (k >= 0) ? mq[k].rd  : '0);
    endtask

    task automatic idle();
        reset = 0; flush = 0; dispatch_en = 0; issue_int = 0; cdb_valid = 0;
        dispatch_opcode = 0; dispatch_rsdata = 0; dispatch_rtdata = 0;
        dispatch_rsvalid = 0; dispatch_rtvalid = 0;
        dispatch_rstag = 0; dispatch_rttag = 0; dispatch_rdtag = 0;
        cdb_tag = 0; cdb_data = 0;
    endtask

    task automatic tick(input string where);
        model_update();
        @(posedge clk);
        #1;
        compare(where);
        idle();
    endtask

    task automatic disp(input logic [3:0] op, input bit rsv, input int rst, input logic [31:0] rsd,
                        input bit rtv, input int rtt, input logic [31:0] rtd, input int rd);
        dispatch_en = 1; dispatch_opcode = op;
        dispatch_rsvalid = rsv; dispatch_rstag = TAGW'(rst); dispatch_rsdata = rsd;
        dispatch_rtvalid = rtv; dispatch_rttag = TAGW'(rtt); dispatch_rtdata = rtd;
        dispatch_rdtag = TAGW'(rd);
    endtask

    task automatic cdb(input int tag, input logic [31:0] data);
        cdb_valid = 1; cdb_tag = TAGW'(tag); cdb_data = data;
    endtask

    task automatic do_reset();
        reset = 1;
        tick("reset");
    endtask

    initial begin
        idle();
        do_reset();

        // Both operands ready at dispatch.
        disp(4'h2, 1, 0, 5, 1, 0, 7, 3);
        tick("basic");
        issue_int = 1;
        tick("basic_issue");

        // Operand woken by a later broadcast.
        disp(4'h5, 0, 9, 0, 1, 0, 11, 4);
        tick("wake_disp");
        cdb(9, 32'hDEAD);
        tick("wake_cdb");
        issue_int = 1;
        tick("wake_issue");

        // Fill with nothing ready, drop the 5th, wake and issue entry 2.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp(4'(i + 1), 0, 20 + i, 0, 1, 0, 100 + i, 10 + i);
            tick("fill");
        end
        disp(4'hF, 1, 0, 1, 1, 0, 2, 30);
        tick("drop_full");
        cdb(22, 32'h222);
        tick("wake_e2");
        issue_int = 1;
        tick("issue_e2");
        cdb(20, 32'h200);
        tick("wake_e0");
        cdb(21, 32'h211);
        issue_int = 1;
        tick("issue_e0");
        cdb(23, 32'h233);
        issue_int = 1;
        tick("issue_e1");
        issue_int = 1;
        tick("issue_e3");

        // Full queue: issue plus dispatch is dropped, then issue plus dispatch holds count.
        do_reset();
        disp(4'h1, 1, 0, 1, 1, 0, 2, 40);
        tick("f2_e0");
        for (int i = 1; i < 4; i++) begin
            disp(4'(i + 1), 0, 40 + i, 0, 1, 0, i, 40 + i);
            tick("f2_fill");
        end
        disp(4'h9, 1, 0, 9, 1, 0, 9, 50);
        issue_int = 1;
        cdb(41, 32'h41);
        tick("f2_issue_drop");
        disp(4'hA, 1, 0, 10, 1, 0, 10, 51);
        issue_int = 1;
        tick("f2_issue_disp");
        issue_int = 1;
        tick("f2_issue_new");
        cdb(42, 32'h42);
        tick("f2_wake");
        issue_int = 1;
        tick("f2_drain");

        // Same-cycle dispatch wakeup.
        do_reset();
        disp(4'h3, 1, 0, 1, 0, 12, 0, 6);
        cdb(12, 44);
        tick("disp_wake");

        // Flush with concurrent dispatch and broadcast; then reset mid-fill.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            disp(4'(i), 0, 30 + i, 0, 0, 33, 0, i);
            tick("pre_flush");
        end
        flush = 1;
        disp(4'h7, 1, 0, 1, 1, 0, 1, 9);
        cdb(30, 32'h30);
        tick("flush");
        for (int i = 0; i < 4; i++) begin
            disp(4'(i), 1, 0, i, 0, 5, 0, i);
            tick("pre_reset");
        end
        reset = 1;
        disp(4'h7, 1, 0, 1, 1, 0, 1, 9);
        cdb(5, 32'h55);
        issue_int = 1;
        flush = 1;
        tick("reset_full");

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            reset     = ($urandom_range(0, 127) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            issue_int = $urandom_range(0, 1);
            if ($urandom_range(0, 2) != 0)
                disp(4'($urandom), $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                     $urandom_range(0, 1), $urandom_range(0, 7), $urandom, $urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1)
                cdb($urandom_range(0, 7), $urandom);
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
